// File: rtl/toggle_energy_monitor_pkg.sv
// Shared types and constants for the toggle/energy activity monitor.
// Energy per transition is derived from load capacitance and supply voltage.
package toggle_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // 15 pF load at 5 V gives C_L*Vcc^2 = 375 pJ per transition.
    localparam int C_L_PF               = 15;
    localparam int VCC_V                = 5;
    localparam int E_PER_TOGGLE_DEFAULT = C_L_PF * VCC_V * VCC_V;

    // Unsigned add clamped to the all-ones value of a w-bit field (w < 64).
    function automatic logic [63:0] sat_add(
        input  logic [63:0] a,
        input  logic [63:0] b,
        input  int unsigned w,
        output logic        clamped
    );
        logic [64:0] sum_v;
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        sum_v = {1'b0, a} + {1'b0, b};
        if (sum_v > {1'b0, max_v}) begin
            clamped = 1'b1;
            return max_v;
        end else begin
            clamped = 1'b0;
            return sum_v[63:0];
        end
    endfunction

endpackage

// File: rtl/popcount_w.sv
// Combinational population count of a WIDTH-bit vector.
module popcount_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             vec,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Sum the set bits one at a time.
    always_comb begin
        count = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/toggle_energy_monitor.sv
// Counts bit transitions on an observed bus over a programmable window and
// reports toggle count and energy (pJ) over a valid/ready handshake.
module toggle_energy_monitor
    import toggle_mon_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 16,
    parameter int ENERGY_W     = 24,
    parameter int E_PER_TOGGLE = E_PER_TOGGLE_DEFAULT,
    parameter int WIN_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIN_W-1:0]    win_len,
    input  logic [WIDTH-1:0]    in_bus,
    output logic                busy,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [CNT_W-1:0]    rpt_toggles,
    output logic [ENERGY_W-1:0] rpt_energy,
    output logic                rpt_sat
);

    localparam int PC_W   = $clog2(WIDTH + 1);
    localparam int PROD_W = CNT_W + $clog2(E_PER_TOGGLE + 1);

    state_t              state_r, state_s;
    logic [WIDTH-1:0]    prev_r, prev_s;
    logic [WIN_W-1:0]    remaining_r, remaining_s;
    logic [CNT_W-1:0]    toggles_r, toggles_s;
    logic [ENERGY_W-1:0] energy_r, energy_s;
    logic                sat_r, sat_s;
    logic                busy_r, busy_s;
    logic                valid_r, valid_s;

    logic [PC_W-1:0]     pc_s;
    logic [PROD_W-1:0]   prod_s;
    logic [CNT_W-1:0]    tog_sum_s;
    logic [ENERGY_W-1:0] en_sum_s;
    logic                tog_clamp_s;
    logic                en_clamp_s;

    popcount_w #(.WIDTH(WIDTH)) u_popcount (
        .vec   (in_bus ^ prev_r),
        .count (pc_s)
    );

    // Per-edge energy increment at full width, then clamped accumulation.
    always_comb begin
        prod_s    = PROD_W'(pc_s) * PROD_W'(E_PER_TOGGLE);
        tog_sum_s = CNT_W'(sat_add(64'(toggles_r), 64'(pc_s), CNT_W, tog_clamp_s));
        en_sum_s  = ENERGY_W'(sat_add(64'(energy_r), 64'(prod_s), ENERGY_W, en_clamp_s));
    end

    // Next-state and next-output logic for the IDLE/MEASURE/REPORT sequence.
    always_comb begin
        state_s     = state_r;
        prev_s      = prev_r;
        remaining_s = remaining_r;
        toggles_s   = toggles_r;
        energy_s    = energy_r;
        sat_s       = sat_r;
        busy_s      = busy_r;
        valid_s     = valid_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // The start cycle only establishes the baseline sample.
                    prev_s      = in_bus;
                    remaining_s = (win_len == {WIN_W{1'b0}}) ? WIN_W'(1) : win_len;
                    toggles_s   = {CNT_W{1'b0}};
                    energy_s    = {ENERGY_W{1'b0}};
                    sat_s       = 1'b0;
                    busy_s      = 1'b1;
                    state_s     = MEASURE;
                end else begin
                    state_s = IDLE;
                end
            end
            MEASURE: begin
                prev_s      = in_bus;
                toggles_s   = tog_sum_s;
                energy_s    = en_sum_s;
                sat_s       = sat_r | tog_clamp_s | en_clamp_s;
                remaining_s = remaining_r - WIN_W'(1);
                if (remaining_r == WIN_W'(1)) begin
                    valid_s = 1'b1;
                    state_s = REPORT;
                end else begin
                    state_s = MEASURE;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = REPORT;
                end
            end
            default: begin
                valid_s = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            prev_r      <= {WIDTH{1'b0}};
            remaining_r <= {WIN_W{1'b0}};
            toggles_r   <= {CNT_W{1'b0}};
            energy_r    <= {ENERGY_W{1'b0}};
            sat_r       <= 1'b0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            remaining_r <= remaining_s;
            toggles_r   <= toggles_s;
            energy_r    <= energy_s;
            sat_r       <= sat_s;
            busy_r      <= busy_s;
            valid_r     <= valid_s;
        end
    end

    assign busy        = busy_r;
    assign rpt_valid   = valid_r;
    assign rpt_toggles = toggles_r;
    assign rpt_energy  = energy_r;
    assign rpt_sat     = sat_r;

endmodule

// File: tb/tb_toggle_energy_monitor.sv
// Directed bench: a default-size monitor and a narrow (8/16-bit) monitor share stimulus.
module tb_toggle_energy_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] win_len;
    logic [7:0]  in_bus;
    logic        rpt_ready;

    logic        busy_a, valid_a, sat_a;
    logic [15:0] tog_a;
    logic [23:0] en_a;
    logic        busy_b, valid_b, sat_b;
    logic [7:0]  tog_b;
    logic [15:0] en_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    toggle_energy_monitor dut_a (
        .clk(clk), .reset(reset), .start(start), .win_len(win_len), .in_bus(in_bus),
        .busy(busy_a), .rpt_valid(valid_a), .rpt_ready(rpt_ready),
        .rpt_toggles(tog_a), .rpt_energy(en_a), .rpt_sat(sat_a)
    );

    toggle_energy_monitor #(.CNT_W(8), .ENERGY_W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start), .win_len(win_len), .in_bus(in_bus),
        .busy(busy_b), .rpt_valid(valid_b), .rpt_ready(rpt_ready),
        .rpt_toggles(tog_b), .rpt_energy(en_b), .rpt_sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic b, input logic v,
                         input logic [31:0] t, input logic [31:0] e, input logic s);
        chk({tag, "_busy"}, 32'(busy_a), 32'(b));
        chk({tag, "_valid"}, 32'(valid_a), 32'(v));
        chk({tag, "_tog"}, 32'(tog_a), t);
        chk({tag, "_en"}, 32'(en_a), e);
        chk({tag, "_sat"}, 32'(sat_a), 32'(s));
    endtask

    task automatic chk_b(input string tag, input logic b, input logic v,
                         input logic [31:0] t, input logic [31:0] e, input logic s);
        chk({tag, "_b_busy"}, 32'(busy_b), 32'(b));
        chk({tag, "_b_valid"}, 32'(valid_b), 32'(v));
        chk({tag, "_b_tog"}, 32'(tog_b), t);
        chk({tag, "_b_en"}, 32'(en_b), e);
        chk({tag, "_b_sat"}, 32'(sat_b), 32'(s));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        win_len   = 16'd0;
        in_bus    = 8'h00;
        rpt_ready = 1'b1;

        // Reset asserted mid-clock with start pending.
        #3;
        start = 1'b1;
        reset = 1'b1;
        #1;
        chk_a("rst_async", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk_b("rst_async", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk_a("rst_held", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(valid_a), 32'd0);
            chk("idle_busy", 32'(busy_a), 32'd0);
        end

        // Quiet bus, win_len=4.
        in_bus  = 8'hA5;
        win_len = 16'd4;
        start   = 1'b1;
        tick();                                   // edge k
        start = 1'b0;
        chk_a("quiet_k", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick(); tick(); tick();                   // k+1..k+3
        chk("quiet_k3_valid", 32'(valid_a), 32'd0);
        tick();                                   // k+4
        chk_a("quiet_rpt", 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        chk_b("quiet_rpt", 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        tick();                                   // accepted
        chk_a("quiet_done", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Full activity, 00/FF alternation, win_len=4.
        in_bus = 8'h00;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_bus = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        chk_a("full", 1'b1, 1'b1, 32'd32, 32'd12000, 1'b0);
        chk_b("full", 1'b1, 1'b1, 32'd32, 32'd12000, 1'b0);
        tick();
        chk("full_done_valid", 32'(valid_a), 32'd0);

        // Backpressure with start pulsed during REPORT.
        rpt_ready = 1'b0;
        win_len   = 16'd3;
        in_bus    = 8'h00;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_bus = (i % 2 == 0) ? 8'h01 : 8'h00;
            tick();
        end
        chk_a("bp_rpt", 1'b1, 1'b1, 32'd3, 32'd1125, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_bus = ~in_bus;
            tick();
            chk_a("bp_hold", 1'b1, 1'b1, 32'd3, 32'd1125, 1'b0);
        end
        rpt_ready = 1'b1;
        tick();                                   // accept with start still high
        start = 1'b0;
        chk_a("bp_accept", 1'b0, 1'b0, 32'd3, 32'd1125, 1'b0);
        tick();
        chk("bp_idle_busy", 32'(busy_a), 32'd0);

        // Saturation: 40 alternating edges.
        win_len = 16'd40;
        in_bus  = 8'h00;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_bus = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        chk_a("sat", 1'b1, 1'b1, 32'd320, 32'd120000, 1'b0);
        chk_b("sat", 1'b1, 1'b1, 32'd255, 32'd65535, 1'b1);
        tick();
        chk_b("sat_done", 1'b0, 1'b0, 32'd255, 32'd65535, 1'b1);

        // win_len=0 behaves as a single comparison; sat clears on start.
        win_len = 16'd0;
        in_bus  = 8'h00;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk_b("wl0_start", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        in_bus = 8'h01;
        tick();
        chk_a("wl0", 1'b1, 1'b1, 32'd1, 32'd375, 1'b0);
        chk_b("wl0", 1'b1, 1'b1, 32'd1, 32'd375, 1'b0);
        tick();

        // Reset two edges into a win_len=10 window.
        win_len = 16'd10;
        in_bus  = 8'h00;
        start   = 1'b1;
        tick();
        start = 1'b0;
        in_bus = 8'hFF;
        tick();
        in_bus = 8'h00;
        tick();
        chk_a("mid_win", 1'b1, 1'b0, 32'd16, 32'd6000, 1'b0);
        reset = 1'b1;
        #1;
        chk_a("mid_rst", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_a("post_rst", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Clean window after reset.
        win_len = 16'd2;
        in_bus  = 8'hA5;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        in_bus = 8'h5A;
        tick();
        tick();
        chk_a("clean", 1'b1, 1'b1, 32'd8, 32'd3000, 1'b0);
        chk_b("clean", 1'b1, 1'b1, 32'd8, 32'd3000, 1'b0);
        tick();
        chk("clean_done", 32'(valid_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/toggle_energy_monitor.md
Name: toggle_energy_monitor

Overview:
Clocked activity monitor and the read side of the gate-level power accounting. Each gate model reports its own transition count and energy through simulation display. This block instead observes a bus of gate outputs, counts bit transitions over a programmable window, and converts them to energy using the per-transition figure C_L·Vcc². It returns the result to a consumer over a valid/ready handshake, so benches and testbench scoreboards can read power figures instead of parsing log text.

Parameters:
WIDTH, 8, number of observed nets
CNT_W, 16, width of toggle accumulator
ENERGY_W, 24, width of energy accumulator
E_PER_TOGGLE, 375, energy per transition in pJ (15 pF · 5 V · 5 V)
WIN_W, 16, width of window length input

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle request to begin a measurement window; honoured only in IDLE
win_len  input  WIN_W  comparisons per window, sampled with start; 0 treated as 1
in_bus  input  WIDTH  observed nets
busy  output  1  high in MEASURE and REPORT
rpt_valid  output  1  result available
rpt_ready  input  1  consumer accepts result
rpt_toggles  output  CNT_W  transitions counted in window
rpt_energy  output  ENERGY_W  accumulated energy, pJ
rpt_sat  output  1  either accumulator saturated during window

Behaviour:
- Reset (async assert): state=IDLE. busy, rpt_valid, rpt_toggles, rpt_energy, rpt_sat, internal prev sample, and window counter are all 0.
- All outputs are registered.
- States:
  - IDLE: start=1 at edge k captures in_bus into prev, loads remaining=max(win_len,1), clears accumulators, and goes to MEASURE.
  - MEASURE: at each edge, t = popcount(in_bus XOR prev); prev <= in_bus; toggles += t; energy += t·E_PER_TOGGLE; remaining -= 1. When remaining reaches 0 (edge k+N), go to REPORT with rpt_valid=1.
  - REPORT: rpt_* held stable while rpt_valid=1 and rpt_ready=0. At an edge with rpt_valid=1 and rpt_ready=1, go to IDLE; rpt_valid and busy are 0 from the next cycle. Data outputs keep their last values.
- Latency: the start edge is k. The window makes N comparisons at edges k+1..k+N. rpt_valid is visible in the cycle after edge k+N.
- The start cycle is a baseline only and never counts toggles.
- start in MEASURE or REPORT is ignored, including in the same cycle as the handshake accept. Back-to-back windows therefore need one IDLE cycle.
- Saturation:
  - Each accumulator clamps at its all-ones value and does not wrap.
  - rpt_sat is set if either accumulator clamps and stays set until the next start.
  - The energy product is computed at full width, CNT_W+bits(E_PER_TOGGLE), before the clamp.
- rpt_ready while not rpt_valid: no effect.
- in_bus is not sampled in IDLE or REPORT. Transitions there are not counted.
- Reset asserted mid-MEASURE or mid-REPORT: immediate return to IDLE with all outputs 0. The partial result is discarded.

Decomposition:
- Package toggle_mon_pkg holds:
  - state enum {IDLE, MEASURE, REPORT}
  - default E_PER_TOGGLE and the C_L/Vcc constants it derives from
  - saturating-add helper function
- One sub-module: popcount_w (combinational, WIDTH in, $clog2(WIDTH+1) out), instantiated once on in_bus XOR prev.

Test Plan:
- Reset: assert reset mid-clock with start pending -> all outputs 0 immediately. No rpt_valid for 10 cycles after release without start.
- Quiet bus: in_bus=8'hA5 constant, start with win_len=4 -> rpt_valid at cycle k+5, toggles=0, energy=0, sat=0.
- Full activity: in_bus alternates 8'h00/8'hFF every cycle, win_len=4 -> toggles=32, energy=12000, sat=0.
- Backpressure: in_bus bit0 toggles each cycle, win_len=3, rpt_ready held 0 for 5 cycles, start pulsed during REPORT -> toggles=3 and energy=1125 stable throughout. start is ignored. rpt_valid drops the cycle after ready=1.
- Saturation: CNT_W=8, ENERGY_W=16, 00/FF alternation, win_len=40 -> toggles=255, energy=65535, sat=1.
- Edge cases: win_len=0 with one bit flip after start -> behaves as N=1, toggles=1, energy=375. Reset asserted 2 cycles into a win_len=10 window -> IDLE, outputs 0, and the next start yields a clean result.
